// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS-to-Avalon bus master: access sizes, FSM states, lane constants.
// Latency: none (types, constants and one pure function only).
// Backpressure: not applicable.
package mips_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_LOAD  = 2'b10,
        ST_STORE = 2'b11
    } state_e;

    // Natural alignment check; the illegal size encoding always counts as misaligned.
    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_byte_lanes.sv
// Little-endian lane steering: byteenable, store replication, load extraction and extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mips_byte_lanes
    import mips_bus_pkg::*;
(
    input  access_size_e            size_i,
    input  logic [1:0]              addr_lo_i,
    input  logic                    is_signed_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [DATA_W-1:0]       rdata_i,
    output logic [LANES-1:0]        byteenable_o,
    output logic [DATA_W-1:0]       wdata_rep_o,
    output logic [DATA_W-1:0]       rdata_ext_o
);

    logic [DATA_W-1:0] shifted;

    // Select lanes by size/offset; loads are shifted down so the addressed byte lands at bit 0.
    always_comb begin
        shifted      = rdata_i >> {addr_lo_i, 3'b000};
        byteenable_o = 4'b1111;
        wdata_rep_o  = wdata_i;
        rdata_ext_o  = shifted;
        case (size_i)
            SZ_BYTE: begin
                byteenable_o = 4'b0001 << addr_lo_i;
                wdata_rep_o  = {4{wdata_i[7:0]}};
                rdata_ext_o  = {{24{is_signed_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byteenable_o = 4'b0011 << addr_lo_i;
                wdata_rep_o  = {2{wdata_i[15:0]}};
                rdata_ext_o  = {{16{is_signed_i & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                byteenable_o = 4'b1111;
                wdata_rep_o  = wdata_i;
                rdata_ext_o  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mips_avalon_master.sv
// MIPS instruction/data ports arbitrated onto one Avalon-MM master; optional stall timeout via MIPS_AVALON_MASTER_TIMEOUT_EN.
// Latency: request in cycle 0, bus command in cycle 1, valid pulse in cycle 2 plus one per waitrequest cycle.
// Backpressure: avm_waitrequest holds the command stable; requests arriving while busy wait in one-entry pending registers.
module mips_avalon_master
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned DATA_PRIORITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_valid,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic        data_signed,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        data_misaligned,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        timeout
);

    state_e             state_q, state_d;
    logic               instr_pend_q, instr_pend_d;
    logic [31:0]        instr_pend_addr_q, instr_pend_addr_d;
    logic               data_pend_q, data_pend_d;
    logic               data_pend_wr_q, data_pend_wr_d;
    logic [31:0]        data_pend_addr_q, data_pend_addr_d;
    access_size_e       data_pend_size_q, data_pend_size_d;
    logic               data_pend_sgn_q, data_pend_sgn_d;
    logic [31:0]        data_pend_wdata_q, data_pend_wdata_d;
    logic [31:0]        txn_addr_q, txn_addr_d;
    access_size_e       txn_size_q, txn_size_d;
    logic               txn_sgn_q, txn_sgn_d;
    logic [31:0]        txn_wdata_q, txn_wdata_d;
    logic [31:0]        instr_rdata_q, instr_rdata_d;
    logic [31:0]        data_rdata_q, data_rdata_d;
    logic               instr_valid_q, instr_valid_d;
    logic               data_valid_q, data_valid_d;
    logic               data_mis_q, data_mis_d;

    // Incoming pulses take part in arbitration in the same cycle as the pending copies.
    logic               data_in, data_any, instr_any, pick_data, bus_st;
    logic               sel_wr, sel_sgn;
    logic [31:0]        sel_addr, sel_wdata, sel_iaddr;
    access_size_e       sel_size;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata, lane_rdata;

    assign data_in   = data_read | data_write;
    assign data_any  = data_in | data_pend_q;
    assign instr_any = instr_req | instr_pend_q;
    assign pick_data = data_any & ((DATA_PRIORITY != 0) | ~instr_any);
    assign sel_wr    = data_in ? data_write : data_pend_wr_q;
    assign sel_addr  = data_in ? data_addr : data_pend_addr_q;
    assign sel_size  = data_in ? access_size_e'(data_size) : data_pend_size_q;
    assign sel_sgn   = data_in ? data_signed : data_pend_sgn_q;
    assign sel_wdata = data_in ? data_wdata : data_pend_wdata_q;
    assign sel_iaddr = instr_req ? instr_addr : instr_pend_addr_q;

    mips_byte_lanes u_lanes (
        .size_i      (txn_size_q),
        .addr_lo_i   (txn_addr_q[1:0]),
        .is_signed_i (txn_sgn_q),
        .wdata_i     (txn_wdata_q),
        .rdata_i     (avm_readdata),
        .byteenable_o(lane_be),
        .wdata_rep_o (lane_wdata),
        .rdata_ext_o (lane_rdata)
    );

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Next-state, pending capture, arbitration and completion handling.
    always_comb begin
        state_d           = state_q;
        instr_pend_d      = instr_pend_q;
        instr_pend_addr_d = instr_pend_addr_q;
        data_pend_d       = data_pend_q;
        data_pend_wr_d    = data_pend_wr_q;
        data_pend_addr_d  = data_pend_addr_q;
        data_pend_size_d  = data_pend_size_q;
        data_pend_sgn_d   = data_pend_sgn_q;
        data_pend_wdata_d = data_pend_wdata_q;
        txn_addr_d        = txn_addr_q;
        txn_size_d        = txn_size_q;
        txn_sgn_d         = txn_sgn_q;
        txn_wdata_d       = txn_wdata_q;
        instr_rdata_d     = instr_rdata_q;
        data_rdata_d      = data_rdata_q;
        instr_valid_d     = 1'b0;
        data_valid_d      = 1'b0;
        data_mis_d        = 1'b0;
`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
        cnt_d             = cnt_q;
        timeout_d         = 1'b0;
`endif
        if (instr_req) begin
            instr_pend_d      = 1'b1;
            instr_pend_addr_d = instr_addr;
        end
        if (data_in) begin
            data_pend_d       = 1'b1;
            data_pend_wr_d    = data_write;
            data_pend_addr_d  = data_addr;
            data_pend_size_d  = access_size_e'(data_size);
            data_pend_sgn_d   = data_signed;
            data_pend_wdata_d = data_wdata;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_data) begin
                    data_pend_d = 1'b0;
                    if (is_misaligned(sel_size, sel_addr[1:0])) begin
                        data_mis_d = 1'b1;
                    end else begin
                        txn_addr_d  = sel_addr;
                        txn_size_d  = sel_size;
                        txn_sgn_d   = sel_sgn;
                        txn_wdata_d = sel_wdata;
                        state_d     = sel_wr ? ST_STORE : ST_LOAD;
`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end else if (instr_any) begin
                    instr_pend_d = 1'b0;
                    txn_addr_d   = sel_iaddr;
                    txn_size_d   = SZ_WORD;
                    txn_sgn_d    = 1'b0;
                    txn_wdata_d  = '0;
                    state_d      = ST_FETCH;
`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            default: begin
                if (!avm_waitrequest) begin
                    state_d = ST_IDLE;
                    case (state_q)
                        ST_FETCH: begin
                            instr_valid_d = 1'b1;
                            instr_rdata_d = avm_readdata;
                        end
                        ST_LOAD: begin
                            data_valid_d = 1'b1;
                            data_rdata_d = lane_rdata;
                        end
                        default: data_valid_d = 1'b1;
                    endcase
                end
`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    if (state_q == ST_FETCH) begin
                        instr_valid_d = 1'b1;
                        instr_rdata_d = '0;
                    end else begin
                        data_valid_d = 1'b1;
                        data_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction and clears pending requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            instr_pend_q      <= 1'b0;
            instr_pend_addr_q <= '0;
            data_pend_q       <= 1'b0;
            data_pend_wr_q    <= 1'b0;
            data_pend_addr_q  <= '0;
            data_pend_size_q  <= SZ_BYTE;
            data_pend_sgn_q   <= 1'b0;
            data_pend_wdata_q <= '0;
            txn_addr_q        <= '0;
            txn_size_q        <= SZ_BYTE;
            txn_sgn_q         <= 1'b0;
            txn_wdata_q       <= '0;
            instr_rdata_q     <= '0;
            data_rdata_q      <= '0;
            instr_valid_q     <= 1'b0;
            data_valid_q      <= 1'b0;
            data_mis_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            instr_pend_q      <= instr_pend_d;
            instr_pend_addr_q <= instr_pend_addr_d;
            data_pend_q       <= data_pend_d;
            data_pend_wr_q    <= data_pend_wr_d;
            data_pend_addr_q  <= data_pend_addr_d;
            data_pend_size_q  <= data_pend_size_d;
            data_pend_sgn_q   <= data_pend_sgn_d;
            data_pend_wdata_q <= data_pend_wdata_d;
            txn_addr_q        <= txn_addr_d;
            txn_size_q        <= txn_size_d;
            txn_sgn_q         <= txn_sgn_d;
            txn_wdata_q       <= txn_wdata_d;
            instr_rdata_q     <= instr_rdata_d;
            data_rdata_q      <= data_rdata_d;
            instr_valid_q     <= instr_valid_d;
            data_valid_q      <= data_valid_d;
            data_mis_q        <= data_mis_d;
        end
    end

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
    // Stall counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    // Bus command is a pure function of state and the latched transaction, so it cannot move while stalled.
    assign bus_st          = (state_q != ST_IDLE);
    assign busy            = bus_st;
    assign avm_read        = (state_q == ST_FETCH) || (state_q == ST_LOAD);
    assign avm_write       = (state_q == ST_STORE);
    assign avm_address     = bus_st ? {txn_addr_q[31:2], 2'b00} : 32'h0;
    assign avm_byteenable  = (state_q == ST_FETCH) ? 4'b1111 : (bus_st ? lane_be : 4'b0000);
    assign avm_writedata   = avm_write ? lane_wdata : 32'h0;
    assign instr_rdata     = instr_rdata_q;
    assign instr_valid     = instr_valid_q;
    assign data_rdata      = data_rdata_q;
    assign data_valid      = data_valid_q;
    assign data_misaligned = data_mis_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Directed bench for mips_avalon_master with a programmable-stall Avalon slave.
// Latency: checks cycle-exact valid, command and misaligned timing.
// Backpressure: the slave holds waitrequest for wait_n cycles of each command.
module tb_mips_avalon_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        data_read, data_write;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_signed;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid, data_misaligned;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, timeout;

    int          errors = 0;
    int          checks = 0;
    int          wait_n = 0;
    int          stall_cnt = 0;
    logic [31:0] slave_rdata = 32'h0;

    // Observations captured by run_data
    logic [31:0] ob_addr, ob_wdata, ob_rdata;
    logic [3:0]  ob_be;
    logic        ob_rd, ob_wr, ob_cmd, ob_busy_end;
    int          ob_unstable, ob_lat, ob_vcnt, ob_mcnt, ob_mfirst, ob_tcnt, ob_tfirst;

    always #5 clk = ~clk;

    assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < wait_n);
    assign avm_readdata    = slave_rdata;

    always @(posedge clk) begin
        if ((avm_read || avm_write) && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    mips_avalon_master #(.TIMEOUT_CYCLES(4), .DATA_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_size(data_size),
        .data_signed(data_signed), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
        .data_misaligned(data_misaligned),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .timeout(timeout)
    );

    // Issue one data request and observe max_cyc cycles after it (cycle 1 = first command cycle).
    task automatic run_data(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata, input int max_cyc);
        @(negedge clk);
        data_read = !wr; data_write = wr; data_addr = addr; data_size = size;
        data_signed = sgn; data_wdata = wdata;
        @(negedge clk);
        data_read = 1'b0; data_write = 1'b0;
        ob_addr = avm_address; ob_be = avm_byteenable; ob_wdata = avm_writedata;
        ob_rd = avm_read; ob_wr = avm_write; ob_cmd = 1'b0; ob_unstable = 0;
        ob_lat = -1; ob_vcnt = 0; ob_mcnt = 0; ob_mfirst = -1; ob_tcnt = 0; ob_tfirst = -1;
        ob_rdata = 32'hxxxxxxxx;
        for (int c = 1; c <= max_cyc; c++) begin
            if (avm_read || avm_write) ob_cmd = 1'b1;
            if (busy && ({avm_address, avm_byteenable, avm_writedata, avm_read, avm_write} !==
                         {ob_addr, ob_be, ob_wdata, ob_rd, ob_wr})) ob_unstable++;
            if (data_valid) begin
                if (ob_lat < 0) begin ob_lat = c; ob_rdata = data_rdata; end
                ob_vcnt++;
            end
            if (data_misaligned) begin
                if (ob_mfirst < 0) ob_mfirst = c;
                ob_mcnt++;
            end
            if (timeout) begin
                if (ob_tfirst < 0) ob_tfirst = c;
                ob_tcnt++;
            end
            @(negedge clk);
        end
        ob_busy_end = busy;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; data_read = 1'b1; data_addr = 32'h0000_1000; data_size = 2'b10;
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, avm_read, avm_write, instr_valid, data_valid, data_misaligned, timeout} !== 7'b0)
            begin errors++; $display("FAIL reset_flags: got %b expected 0000000", {busy, avm_read, avm_write, instr_valid, data_valid, data_misaligned, timeout}); end
        checks++; if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0)
            begin errors++; $display("FAIL reset_bus: got %h expected 0", {avm_address, avm_writedata, avm_byteenable}); end
        checks++; if ({data_rdata, instr_rdata} !== 64'h0)
            begin errors++; $display("FAIL reset_rdata: got %h expected 0", {data_rdata, instr_rdata}); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({busy, avm_read} !== 2'b00)
            begin errors++; $display("FAIL reset_discard: got busy/read %b expected 00", {busy, avm_read}); end
    endtask

    task automatic test_word_load;
        wait_n = 2; slave_rdata = 32'h1234_5678;
        run_data(1'b0, 32'hBFC0_0004, 2'b10, 1'b0, 32'h0, 8);
        checks++; if (ob_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL wload_addr: got %h expected bfc00004", ob_addr); end
        checks++; if ({ob_rd, ob_wr, ob_be} !== 6'b10_1111) begin errors++; $display("FAIL wload_cmd: got %b expected 101111", {ob_rd, ob_wr, ob_be}); end
        checks++; if (ob_lat !== 4) begin errors++; $display("FAIL wload_lat: got %0d expected 4", ob_lat); end
        checks++; if (ob_vcnt !== 1) begin errors++; $display("FAIL wload_vcnt: got %0d expected 1", ob_vcnt); end
        checks++; if (ob_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wload_rdata: got %h expected 12345678", ob_rdata); end
        checks++; if (ob_unstable !== 0) begin errors++; $display("FAIL wload_stable: got %0d changes expected 0", ob_unstable); end
        checks++; if (ob_busy_end !== 1'b0) begin errors++; $display("FAIL wload_busy: got %b expected 0", ob_busy_end); end
    endtask

    task automatic test_byte_load;
        wait_n = 0; slave_rdata = 32'h80FF_FF12;
        run_data(1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0, 5);
        checks++; if (ob_addr !== 32'h0000_1000) begin errors++; $display("FAIL sbyte_addr: got %h expected 00001000", ob_addr); end
        checks++; if (ob_be !== 4'b1000) begin errors++; $display("FAIL sbyte_be: got %b expected 1000", ob_be); end
        checks++; if (ob_lat !== 2) begin errors++; $display("FAIL sbyte_lat: got %0d expected 2", ob_lat); end
        checks++; if (ob_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_rdata: got %h expected ffffff80", ob_rdata); end
        run_data(1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0, 5);
        checks++; if (ob_rdata !== 32'h0000_0080) begin errors++; $display("FAIL ubyte_rdata: got %h expected 00000080", ob_rdata); end
    endtask

    task automatic test_store;
        wait_n = 3;
        run_data(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_ABCD, 8);
        checks++; if (ob_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL hstore_wdata: got %h expected abcdabcd", ob_wdata); end
        checks++; if ({ob_rd, ob_wr, ob_be} !== 6'b01_1100) begin errors++; $display("FAIL hstore_cmd: got %b expected 011100", {ob_rd, ob_wr, ob_be}); end
        checks++; if (ob_unstable !== 0) begin errors++; $display("FAIL hstore_stable: got %0d changes expected 0", ob_unstable); end
        checks++; if (ob_lat !== 5) begin errors++; $display("FAIL hstore_lat: got %0d expected 5", ob_lat); end
        checks++; if (data_rdata !== 32'h0000_0080) begin errors++; $display("FAIL hstore_rdata_hold: got %h expected 00000080", data_rdata); end
        wait_n = 0;
        run_data(1'b1, 32'h0000_2001, 2'b00, 1'b0, 32'h0000_005A, 4);
        checks++; if ({ob_wdata, ob_be} !== {32'h5A5A_5A5A, 4'b0010}) begin errors++; $display("FAIL bstore: got %h/%b expected 5a5a5a5a/0010", ob_wdata, ob_be); end
    endtask

    task automatic test_misaligned;
        wait_n = 0;
        run_data(1'b0, 32'h0000_0102, 2'b10, 1'b0, 32'h0, 5);
        checks++; if (ob_cmd !== 1'b0) begin errors++; $display("FAIL mis_cmd: got %b expected 0", ob_cmd); end
        checks++; if ({ob_mcnt, ob_mfirst} !== {32'sd1, 32'sd1}) begin errors++; $display("FAIL mis_pulse: got count %0d at %0d expected 1 at 1", ob_mcnt, ob_mfirst); end
        checks++; if (ob_vcnt !== 0) begin errors++; $display("FAIL mis_valid: got %0d expected 0", ob_vcnt); end
        run_data(1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0, 4);
        checks++; if ({ob_cmd, ob_mcnt} !== {1'b0, 32'sd1}) begin errors++; $display("FAIL mis_illegal: got cmd %b count %0d expected 0/1", ob_cmd, ob_mcnt); end
    endtask

    task automatic test_priority;
        int dv, dcnt, fc, iv, icnt;
        logic [3:0]  fbe;
        logic [31:0] irdata, drdata;
        dv = -1; dcnt = 0; fc = -1; iv = -1; icnt = 0; fbe = 4'h0; irdata = 32'h0; drdata = 32'h0;
        wait_n = 1; slave_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0040_0006;
        data_read = 1'b1; data_addr = 32'h0000_3000; data_size = 2'b10; data_signed = 1'b0;
        @(negedge clk);
        instr_req = 1'b0; data_read = 1'b0;
        checks++; if ({avm_read, avm_address} !== {1'b1, 32'h0000_3000}) begin errors++; $display("FAIL prio_first: got %b/%h expected 1/00003000", avm_read, avm_address); end
        for (int c = 1; c <= 10; c++) begin
            if (data_valid) begin if (dv < 0) begin dv = c; drdata = data_rdata; end dcnt++; end
            if (instr_valid) begin if (iv < 0) begin iv = c; irdata = instr_rdata; end icnt++; end
            if (avm_read && avm_address == 32'h0040_0004 && fc < 0) begin fc = c; fbe = avm_byteenable; end
            @(negedge clk);
        end
        checks++; if ({dv, dcnt} !== {32'sd3, 32'sd1}) begin errors++; $display("FAIL prio_dvalid: got at %0d count %0d expected at 3 count 1", dv, dcnt); end
        checks++; if ({fc, fbe} !== {32'sd4, 4'b1111}) begin errors++; $display("FAIL prio_fetch_cmd: got at %0d be %b expected at 4 be 1111", fc, fbe); end
        checks++; if ({iv, icnt} !== {32'sd6, 32'sd1}) begin errors++; $display("FAIL prio_ivalid: got at %0d count %0d expected at 6 count 1", iv, icnt); end
        checks++; if ({irdata, drdata} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin errors++; $display("FAIL prio_rdata: got %h/%h expected cafef00d/cafef00d", irdata, drdata); end
    endtask

    task automatic test_reset_mid_store;
        int vc;
        vc = 0;
        wait_n = 100;
        @(negedge clk);
        data_write = 1'b1; data_addr = 32'h0000_4000; data_size = 2'b10; data_wdata = 32'h1122_3344;
        @(negedge clk);
        data_write = 1'b0;
        checks++; if (avm_write !== 1'b1) begin errors++; $display("FAIL rst_store_cmd: got %b expected 1", avm_write); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({avm_write, busy} !== 2'b00) begin errors++; $display("FAIL rst_store_abort: got %b expected 00", {avm_write, busy}); end
        for (int c = 0; c < 5; c++) begin
            if (data_valid) vc++;
            @(negedge clk);
        end
        checks++; if (vc !== 0) begin errors++; $display("FAIL rst_store_valid: got %0d expected 0", vc); end
        wait_n = 0;
    endtask

    task automatic test_timeout;
`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
        wait_n = 100; slave_rdata = 32'h5555_5555;
        run_data(1'b0, 32'h0000_5000, 2'b10, 1'b0, 32'h0, 8);
        checks++; if ({ob_lat, ob_tfirst} !== {32'sd5, 32'sd5}) begin errors++; $display("FAIL tmo_cycle: got valid %0d timeout %0d expected 5/5", ob_lat, ob_tfirst); end
        checks++; if ({ob_vcnt, ob_tcnt} !== {32'sd1, 32'sd1}) begin errors++; $display("FAIL tmo_count: got %0d/%0d expected 1/1", ob_vcnt, ob_tcnt); end
        checks++; if (ob_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", ob_rdata); end
        checks++; if (ob_busy_end !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", ob_busy_end); end
        wait_n = 0;
`else
        int vc;
        vc = 0;
        wait_n = 100; slave_rdata = 32'h5555_5555;
        run_data(1'b0, 32'h0000_5000, 2'b10, 1'b0, 32'h0, 20);
        checks++; if ({ob_tcnt, ob_vcnt} !== {32'sd0, 32'sd0}) begin errors++; $display("FAIL notmo_pulses: got timeout %0d valid %0d expected 0/0", ob_tcnt, ob_vcnt); end
        checks++; if ({ob_busy_end, ob_unstable} !== {1'b1, 32'sd0}) begin errors++; $display("FAIL notmo_stall: got busy %b changes %0d expected 1/0", ob_busy_end, ob_unstable); end
        wait_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (data_valid) vc++;
            @(negedge clk);
        end
        checks++; if ({vc, data_rdata} !== {32'sd1, 32'h5555_5555}) begin errors++; $display("FAIL notmo_release: got %0d/%h expected 1/55555555", vc, data_rdata); end
`endif
    endtask

    initial begin
        rst = 1'b1; instr_req = 1'b0; instr_addr = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_addr = 32'h0; data_size = 2'b00;
        data_signed = 1'b0; data_wdata = 32'h0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_store();
        test_misaligned();
        test_priority();
        test_reset_mid_store();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
